// File: rtl/adder_out_router_if.sv
// Bundle between the adder FU, the egress router and the four neighbour links.
// The master drives results, config and link ready; the slave drives flits and status.
interface adder_out_router_if #(
    parameter int WIDTH = 16
);
    logic [3:0][WIDTH-1:0] fu_results;
    logic                  fu_ack;
    logic [15:0]           config_in;
    logic                  in_ready;
    logic [3:0][WIDTH-1:0] dout_data;
    logic [3:0]            dout_valid;
    logic [3:0]            dout_last;
    logic [3:0]            dout_ready;
    logic                  busy;
    logic                  err_ovf;
    logic                  err_cfg;

    modport master (
        output fu_results, fu_ack, config_in, dout_ready,
        input  in_ready, dout_data, dout_valid, dout_last, busy, err_ovf, err_cfg
    );

    modport slave (
        input  fu_results, fu_ack, config_in, dout_ready,
        output in_ready, dout_data, dout_valid, dout_last, busy, err_ovf, err_cfg
    );
endinterface

// File: rtl/adder_out_router.sv
// Egress router for the tile adder: buffers 4-lane result bundles and serializes them lane by
// lane into registered flits toward the N/E/S/W neighbour chosen by the captured config word.
//   state  | meaning
//   IDLE   | no flit on the links, waiting for a buffered bundle
//   SEND   | one flit of the head bundle presented; lane_q is its lane index
module adder_out_router #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    adder_out_router_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [0:0]    S_IDLE    = 1'b0;
    localparam logic [0:0]    S_SEND    = 1'b1;

    logic [3:0][WIDTH-1:0] fifo_data_q [DEPTH];
    logic [1:0]            fifo_mode_q [DEPTH];
    logic [7:0]            fifo_dest_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic [0:0]            state_q, state_d;
    logic [1:0]            lane_q, lane_d;
    logic [3:0]            dv_q, dv_d, dl_q, dl_d;
    logic [3:0][WIDTH-1:0] dd_q, dd_d;
    logic                  err_ovf_q, err_cfg_q;

    logic          cfg_bad, full, push, drop_ovf, retire, pop, load;
    logic [AW-1:0] load_ptr;
    logic [1:0]    load_lane, sel, dir;
    logic          last;
    logic          unused_cfg;

    assign unused_cfg = ^bus.config_in[7:2];

    // Full is judged on occupancy before this edge's pop, so a same-edge pop never rescues an ack.
    assign cfg_bad  = bus.fu_ack && (bus.config_in[1:0] == 2'd2);
    assign full     = (count_q == DEPTH_C);
    assign push     = bus.fu_ack && !cfg_bad && !full;
    assign drop_ovf = bus.fu_ack && !cfg_bad && full;
    assign retire   = (state_q == S_SEND) && |(dv_q & bus.dout_ready);
    assign pop      = retire && (lane_q == 2'd3);

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        dv_d      = dv_q;
        dd_d      = dd_q;
        dl_d      = dl_q;
        load      = 1'b0;
        load_ptr  = rd_ptr_q;
        load_lane = 2'd0;
        if (state_q == S_IDLE) begin
            if (count_q != '0) begin
                load    = 1'b1;
                state_d = S_SEND;
            end
        end else if (retire) begin
            if (lane_q != 2'd3) begin
                load      = 1'b1;
                load_lane = lane_q + 2'd1;
            end else if (count_q > COUNT_ONE) begin
                load     = 1'b1;
                load_ptr = rd_ptr_q + PTR_ONE;
            end else begin
                state_d = S_IDLE;
                dv_d    = '0;
                dd_d    = '0;
                dl_d    = '0;
            end
        end

        case (fifo_mode_q[load_ptr])
            2'd0:    sel = load_lane;
            2'd1:    sel = {load_lane[1], 1'b0};
            default: sel = 2'd0;
        endcase
        dir = fifo_dest_q[load_ptr][{sel, 1'b0} +: 2];
        case (fifo_mode_q[load_ptr])
            2'd0:    last = 1'b1;
            2'd1:    last = load_lane[0];
            default: last = (load_lane == 2'd3);
        endcase

        if (load) begin
            lane_d      = load_lane;
            dv_d        = '0;
            dd_d        = '0;
            dl_d        = '0;
            dv_d[dir]   = 1'b1;
            dd_d[dir]   = fifo_data_q[load_ptr][load_lane];
            dl_d[dir]   = last;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)
            count_d = count_q + COUNT_ONE;
        else if (pop && !push)
            count_d = count_q - COUNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_mode_q[i] <= '0;
                fifo_dest_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            lane_q    <= '0;
            dv_q      <= '0;
            dd_q      <= '0;
            dl_q      <= '0;
            err_ovf_q <= 1'b0;
            err_cfg_q <= 1'b0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= bus.fu_results;
                fifo_mode_q[wr_ptr_q] <= bus.config_in[1:0];
                fifo_dest_q[wr_ptr_q] <= bus.config_in[15:8];
            end
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            lane_q    <= lane_d;
            dv_q      <= dv_d;
            dd_q      <= dd_d;
            dl_q      <= dl_d;
            err_ovf_q <= err_ovf_q | drop_ovf;
            err_cfg_q <= err_cfg_q | cfg_bad;
        end
    end

    assign bus.dout_valid = dv_q;
    assign bus.dout_data  = dd_q;
    assign bus.dout_last  = dl_q;
    assign bus.in_ready   = !full;
    assign bus.busy       = (count_q != '0) || (|dv_q);
    assign bus.err_ovf    = err_ovf_q;
    assign bus.err_cfg    = err_cfg_q;
endmodule

// File: tb/tb_adder_out_router.sv
// Self-checking bench for adder_out_router: a bundle-queue/flit-list model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_adder_out_router;
    localparam int WIDTH = 16;
    localparam int DEPTH = 2;

    typedef struct {
        logic [63:0] res;
        logic [1:0]  mode;
        logic [7:0]  dest;
    } bundle_t;

    typedef struct {
        int          dir;
        logic [15:0] data;
        logic        last;
    } flit_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    bundle_t q[$];
    flit_t   fl[$];
    logic    m_ovf, m_cfg;

    adder_out_router_if #(.WIDTH(WIDTH)) bus ();

    adder_out_router #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expand one bundle into its four flits in lane order.
    task automatic expand(input bundle_t b);
        for (int k = 0; k < 4; k++) begin
            flit_t f;
            int    src;
            src    = (b.mode == 2'd0) ? k : (b.mode == 2'd1) ? ((k < 2) ? 0 : 2) : 0;
            f.dir  = int'(b.dest[2*src +: 2]);
            f.data = b.res[16*k +: 16];
            f.last = (b.mode == 2'd0) ? 1'b1 : (b.mode == 2'd1) ? (k % 2 == 1) : (k == 3);
            fl.push_back(f);
        end
    endtask

    task automatic model_edge(input logic ack, input logic [63:0] res, input logic [15:0] cfg,
                              input logic [3:0] rdy, input logic rst);
        int occ_before;
        if (rst) begin
            q.delete();
            fl.delete();
            m_ovf = 1'b0;
            m_cfg = 1'b0;
            return;
        end
        occ_before = q.size();
        if (fl.size() != 0) begin
            if (rdy[fl[0].dir]) begin
                void'(fl.pop_front());
                if (fl.size() == 0) begin
                    void'(q.pop_front());
                    if (q.size() != 0) expand(q[0]);
                end
            end
        end else if (q.size() != 0) begin
            expand(q[0]);
        end
        if (ack) begin
            if (cfg[1:0] == 2'd2) m_cfg = 1'b1;
            else if (occ_before == DEPTH) m_ovf = 1'b1;
            else begin
                bundle_t b;
                b.res  = res;
                b.mode = cfg[1:0];
                b.dest = cfg[15:8];
                q.push_back(b);
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0]       ev, el;
        logic [3:0][15:0] ed;
        ev = '0;
        el = '0;
        ed = '0;
        if (fl.size() != 0) begin
            ev[fl[0].dir] = 1'b1;
            ed[fl[0].dir] = fl[0].data;
            el[fl[0].dir] = fl[0].last;
        end
        chk("model_valid", 64'(bus.dout_valid), 64'(ev));
        chk("model_data", 64'(bus.dout_data), 64'(ed));
        chk("model_last", 64'(bus.dout_last), 64'(el));
        chk("model_busy", 64'(bus.busy), 64'((q.size() != 0) || (fl.size() != 0)));
        chk("model_in_ready", 64'(bus.in_ready), 64'(q.size() < DEPTH));
        chk("model_err_ovf", 64'(bus.err_ovf), 64'(m_ovf));
        chk("model_err_cfg", 64'(bus.err_cfg), 64'(m_cfg));
    endtask

    // Drive inputs just after an edge, advance one edge, update the model, then compare.
    task automatic step(input logic ack, input logic [63:0] res, input logic [15:0] cfg,
                        input logic [3:0] rdy, input logic rst);
        reset          = rst;
        bus.fu_ack     = ack;
        bus.fu_results = res;
        bus.config_in  = cfg;
        bus.dout_ready = rdy;
        @(posedge clk);
        model_edge(ack, res, cfg, rdy, rst);
        #1;
        compare_all();
    endtask

    task automatic idle(input logic [3:0] rdy);
        step(1'b0, 64'h0, 16'h0, rdy, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_ovf    = 1'b0;
        m_cfg    = 1'b0;
        reset          = 1'b1;
        bus.fu_ack     = 1'b0;
        bus.fu_results = '0;
        bus.config_in  = '0;
        bus.dout_ready = '0;

        step(1'b0, 64'h0, 16'h0, 4'h0, 1'b1);
        step(1'b0, 64'h0, 16'h0, 4'h0, 1'b1);
        chk("reset_valid", 64'(bus.dout_valid), 64'h0);
        chk("reset_in_ready", 64'(bus.in_ready), 64'h1);
        chk("reset_busy", 64'(bus.busy), 64'h0);

        // Reset in the middle of a stalled transfer.
        step(1'b1, 64'h1111_2222_3333_4444, 16'hE400, 4'h0, 1'b0);
        idle(4'h0);
        idle(4'h0);
        chk("midsend_valid", 64'(bus.dout_valid), 64'h1);
        step(1'b0, 64'h0, 16'h0, 4'h0, 1'b1);
        chk("rst_mid_valid", 64'(bus.dout_valid), 64'h0);
        chk("rst_mid_busy", 64'(bus.busy), 64'h0);
        chk("rst_mid_in_ready", 64'(bus.in_ready), 64'h1);

        // mode0, one lane to each direction.
        step(1'b1, 64'h0004_0003_0002_0001, 16'hE400, 4'hF, 1'b0);
        idle(4'hF);
        chk("m0_f0_valid", 64'(bus.dout_valid), 64'b0001);
        chk("m0_f0_data", 64'(bus.dout_data[0]), 64'h1);
        chk("m0_f0_last", 64'(bus.dout_last), 64'b0001);
        idle(4'hF);
        chk("m0_f1_data", 64'(bus.dout_data[1]), 64'h2);
        chk("m0_f1_valid", 64'(bus.dout_valid), 64'b0010);
        idle(4'hF);
        chk("m0_f2_data", 64'(bus.dout_data[2]), 64'h3);
        idle(4'hF);
        chk("m0_f3_data", 64'(bus.dout_data[3]), 64'h4);
        chk("m0_f3_last", 64'(bus.dout_last), 64'b1000);
        idle(4'hF);
        chk("m0_done_busy", 64'(bus.busy), 64'h0);

        // mode1, low pair to E, high pair to W.
        step(1'b1, 64'hDDDD_CCCC_BBBB_AAAA, 16'h3101, 4'hF, 1'b0);
        idle(4'hF);
        chk("m1_f0_data", 64'(bus.dout_data[1]), 64'hAAAA);
        chk("m1_f0_last", 64'(bus.dout_last), 64'b0000);
        idle(4'hF);
        chk("m1_f1_data", 64'(bus.dout_data[1]), 64'hBBBB);
        chk("m1_f1_last", 64'(bus.dout_last), 64'b0010);
        idle(4'hF);
        chk("m1_f2_valid", 64'(bus.dout_valid), 64'b1000);
        chk("m1_f2_data", 64'(bus.dout_data[3]), 64'hCCCC);
        idle(4'hF);
        chk("m1_f3_data", 64'(bus.dout_data[3]), 64'hDDDD);
        chk("m1_f3_last", 64'(bus.dout_last), 64'b1000);
        idle(4'hF);

        // mode3 to S with ready toggling.
        step(1'b1, 64'h4444_3333_2222_1111, 16'h0203, 4'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            idle((i % 2 == 0) ? 4'b0100 : 4'b0000);
            if (i == 0) begin
                chk("m3_f0_valid", 64'(bus.dout_valid), 64'b0100);
                chk("m3_f0_data", 64'(bus.dout_data[2]), 64'h1111);
            end
            if (i == 6) chk("m3_f3_last", 64'(bus.dout_last), 64'b0100);
        end
        chk("m3_done_busy", 64'(bus.busy), 64'h0);

        // Overflow with DEPTH=2.
        step(1'b1, 64'h0A0A_0909_0808_0707, 16'h0000, 4'h0, 1'b0);
        step(1'b1, 64'h0E0E_0D0D_0C0C_0B0B, 16'h5500, 4'h0, 1'b0);
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 16'hAA00, 4'h0, 1'b0);
        chk("ovf_err", 64'(bus.err_ovf), 64'h1);
        chk("ovf_in_ready", 64'(bus.in_ready), 64'h0);
        for (int i = 0; i < 10; i++) idle(4'hF);
        chk("ovf_drain_in_ready", 64'(bus.in_ready), 64'h1);
        chk("ovf_drain_busy", 64'(bus.busy), 64'h0);

        // Reserved mode is dropped, then a normal bundle routes.
        step(1'b0, 64'h0, 16'h0, 4'h0, 1'b1);
        step(1'b1, 64'h1234_1234_1234_1234, 16'hFF02, 4'hF, 1'b0);
        chk("cfg_err", 64'(bus.err_cfg), 64'h1);
        chk("cfg_busy", 64'(bus.busy), 64'h0);
        step(1'b1, 64'h0040_0030_0020_0010, 16'h1B00, 4'hF, 1'b0);
        idle(4'hF);
        chk("cfg_next_valid", 64'(bus.dout_valid), 64'b1000);
        chk("cfg_next_data", 64'(bus.dout_data[3]), 64'h10);
        for (int i = 0; i < 5; i++) idle(4'hF);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            logic [1:0]  md;
            logic [15:0] cfg;
            int          r;
            r   = $urandom_range(0, 15);
            md  = (r == 0) ? 2'd2 : (r % 3 == 0) ? 2'd0 : (r % 3 == 1) ? 2'd1 : 2'd3;
            cfg = {8'($urandom), 6'($urandom), md};
            step($urandom_range(0, 2) == 0, {$urandom, $urandom}, cfg,
                 4'($urandom_range(0, 15)), $urandom_range(0, 299) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
